// File: rtl/seg_display_scheduler.sv
// Seven-segment digit multiplexer with keypad/switch ownership arbitration.
// Optional inter-digit blanking is enabled by defining SEG_BLANK_EN.
module seg_display_scheduler #(
  parameter int NDIG      = 2,
  parameter int DWELLBITS = 10,
  parameter int BLANKCYC  = 4,
  parameter int TOBITS    = 16
) (
  input  logic                clk1,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic                kp_valid,
  input  logic [3:0]          kp_digit,
  input  logic [4*NDIG-1:0]   sw_digits,
  output logic [NDIG-1:0]     enables,
  output logic [3:0]          seg_digit,
  output logic                owner,
  output logic                blank
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int BW = (BLANKCYC > 1) ? $clog2(BLANKCYC) : 1;
  localparam int CW = (DWELLBITS > BW) ? DWELLBITS : BW;
  localparam logic [CW-1:0] DWELL_LAST = CW'((64'd1 << DWELLBITS) - 64'd1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
`ifdef SEG_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANKCYC - 1);
`endif

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t              state_reg;
  logic [CW-1:0]       cnt_reg;
  logic [IW-1:0]       idx_reg;
  logic [IW-1:0]       idx_next;
  logic [TOBITS-1:0]   tocnt_reg;
  logic [4*NDIG-1:0]   kh_reg;
  logic [3:0]          cand [NDIG];

  assign idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);

  // Candidate digit per position, chosen by the owner registered before the edge.
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_cand
      assign cand[gi] = owner ? kh_reg[4*gi +: 4] : sw_digits[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk1) begin
    if (reset) begin
      kh_reg <= '0;
    end else if (kp_valid) begin
      if (NDIG > 1)
        kh_reg <= {kh_reg[4*NDIG-5:0], kp_digit};
      else
        kh_reg <= {kp_digit};
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      owner     <= 1'b0;
      tocnt_reg <= '0;
    end else begin
      case (mode)
        2'b01: begin
          owner     <= 1'b1;
          tocnt_reg <= '0;
        end
        2'b10: begin
          // A fresh keypress always reloads, even on the expiry cycle.
          if (kp_valid) begin
            owner     <= 1'b1;
            tocnt_reg <= '1;
          end else if (owner) begin
            if (tocnt_reg == '0)
              owner <= 1'b0;
            else
              tocnt_reg <= tocnt_reg - TOBITS'(1);
          end
        end
        default: begin
          owner     <= 1'b0;
          tocnt_reg <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_reg <= ST_BLANK;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      enables   <= '0;
      seg_digit <= 4'h0;
      blank     <= 1'b1;
    end else begin
      case (state_reg)
        ST_BLANK: begin
`ifdef SEG_BLANK_EN
          if (cnt_reg == BLANK_LAST) begin
            state_reg <= ST_SHOW;
            cnt_reg   <= '0;
            enables   <= NDIG'(1) << idx_reg;
            seg_digit <= cand[idx_reg];
            blank     <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
`else
          state_reg <= ST_SHOW;
          cnt_reg   <= '0;
          enables   <= NDIG'(1) << idx_reg;
          seg_digit <= cand[idx_reg];
          blank     <= 1'b0;
`endif
        end
        default: begin
          if (cnt_reg == DWELL_LAST) begin
            cnt_reg <= '0;
            idx_reg <= idx_next;
`ifdef SEG_BLANK_EN
            state_reg <= ST_BLANK;
            enables   <= '0;
            blank     <= 1'b1;
`else
            // Back-to-back visits: next digit is latched on the same edge.
            enables   <= NDIG'(1) << idx_next;
            seg_digit <= cand[idx_next];
`endif
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
